ram_transfer_scalar_mul: RTL and testbench

- Block-move engine inside the ECC scalar-multiplication subsystem.
- Copies 1–3 consecutive 256-bit words between the outer (host-visible) RAM port and the inner (point add/double) RAM port.
- Each copy is started by a command pulse from the scalar-multiplication controller and completion is signalled by a one-cycle interrupt.
- While a move runs, the top level routes the outer RAM address bus from this block, using transfer_running as the select.

---
 rtl/ram_transfer_scalar_mul_if.sv | 36 +++
 rtl/ram_transfer_scalar_mul.sv | 107 ++++++++++
 tb/tb_ram_transfer_scalar_mul.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_transfer_scalar_mul_if.sv
// Bus bundle for the scalar-mul block-move engine: command inputs from the
// controller, both RAM ports, and the running/done status.
interface ram_transfer_scalar_mul_if #(
    parameter int DATA = 255,
    parameter int ADDR = 5
);
    logic            command_transfer;
    logic            read_write_command;
    logic [ADDR:0]   read_address;
    logic [ADDR:0]   write_address;
    logic [1:0]      no_of_chunks;
    logic            b_w;
    logic [ADDR:0]   b_adbus;
    logic [DATA:0]   b_data_in;
    logic [DATA:0]   b_data_out;
    logic            a_w;
    logic [ADDR:0]   a_adbus;
    logic [DATA:0]   a_data_in;
    logic [DATA:0]   a_data_out;
    logic            interupt_transfer;
    logic            transfer_running;

    modport slave (
        input  command_transfer, read_write_command, read_address, write_address,
               no_of_chunks, b_data_out, a_data_out,
        output b_w, b_adbus, b_data_in, a_w, a_adbus, a_data_in,
               interupt_transfer, transfer_running
    );

    modport master (
        output command_transfer, read_write_command, read_address, write_address,
               no_of_chunks, b_data_out, a_data_out,
        input  b_w, b_adbus, b_data_in, a_w, a_adbus, a_data_in,
               interupt_transfer, transfer_running
    );
endinterface

// File: rtl/ram_transfer_scalar_mul.sv
// Block-move engine copying 1-3 words between outer (b) and inner (a) RAM ports.
// Define TRANSFER_PIPELINE_EN to overlap the read of word i+1 with the write of word i.
module ram_transfer_scalar_mul #(
    parameter int DATA = 255,
    parameter int ADDR = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ram_transfer_scalar_mul_if.slave    bus
);
    localparam int ADDR_W = ADDR + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;  // sole active state in pipelined build
    localparam logic [1:0] S_DONE  = 2'd3;
`ifndef TRANSFER_PIPELINE_EN
    localparam logic [1:0] S_WRITE = 2'd2;
`endif

    logic [1:0]    state;
    logic          dir;     // 1: outer -> inner
    logic [ADDR:0] rbase;
    logic [ADDR:0] wbase;
    logic [1:0]    n;
    logic [1:0]    idx;
    logic          last;
    logic          rd_en, wr_en, running;
    logic [ADDR:0] rd_addr, wr_addr;

`ifdef TRANSFER_PIPELINE_EN
    // idx counts N+1 slots: reads in 0..N-1, writes trail by one in 1..N
    assign last    = (idx == n);
    assign running = (state == S_READ);
    assign rd_en   = running && (idx != n);
    assign wr_en   = running && (idx != 2'd0);
    assign rd_addr = rbase + ADDR_W'(idx);
    assign wr_addr = wbase + ADDR_W'(idx) - ADDR_W'(1);
`else
    assign last    = ({1'b0, idx} + 3'd1) >= {1'b0, n};
    assign running = (state == S_READ) || (state == S_WRITE);
    assign rd_en   = running;
    assign wr_en   = (state == S_WRITE);
    assign rd_addr = rbase + ADDR_W'(idx);
    assign wr_addr = wbase + ADDR_W'(idx);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            dir   <= 1'b0;
            rbase <= '0;
            wbase <= '0;
            n     <= '0;
            idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.command_transfer) begin
                        dir   <= bus.read_write_command;
                        rbase <= bus.read_address;
                        wbase <= bus.write_address;
                        n     <= bus.no_of_chunks;
                        idx   <= '0;
                        state <= (bus.no_of_chunks == 2'd0) ? S_DONE : S_READ;
                    end
                end
`ifdef TRANSFER_PIPELINE_EN
                S_READ: begin
                    if (last) state <= S_DONE;
                    else      idx   <= idx + 2'd1;
                end
`else
                S_READ:  state <= S_WRITE;
                S_WRITE: begin
                    if (last) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= S_READ;
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Destination data is the source RAM's registered output, passed straight through.
    always_comb begin
        bus.b_w       = wr_en & ~dir;
        bus.a_w       = wr_en & dir;
        bus.b_adbus   = '0;
        bus.a_adbus   = '0;
        if (dir) begin
            if (rd_en) bus.b_adbus = rd_addr;
            if (wr_en) bus.a_adbus = wr_addr;
        end else begin
            if (rd_en) bus.a_adbus = rd_addr;
            if (wr_en) bus.b_adbus = wr_addr;
        end
        bus.b_data_in = (wr_en & ~dir) ? bus.a_data_out : '0;
        bus.a_data_in = (wr_en & dir)  ? bus.b_data_out : '0;
        bus.transfer_running  = running;
        bus.interupt_transfer = (state == S_DONE);
    end
endmodule

// File: tb/tb_ram_transfer_scalar_mul.sv
// Bench for ram_transfer_scalar_mul: RAM models, write scoreboard, vector table
// plus hand sequences for overlapping commands and mid-move reset.
module tb_ram_transfer_scalar_mul;
    localparam int DATA = 255;
    localparam int ADDR = 5;
`ifdef TRANSFER_PIPELINE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    typedef logic [DATA:0] word_t;
    typedef logic [ADDR:0] addr_t;

    typedef struct {
        logic       port;   // 1 = outer
        addr_t      addr;
        word_t      data;
    } wr_t;

    typedef struct {
        logic       rw;
        addr_t      ra;
        addr_t      wa;
        logic [1:0] n;
        int         exp_int;
        int         exp_run;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_transfer_scalar_mul_if #(.DATA(DATA), .ADDR(ADDR)) bus ();
    ram_transfer_scalar_mul #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    word_t outer_mem [64];
    word_t inner_mem [64];
    logic  pk_en = 1'b0, pk_sel = 1'b0;
    addr_t pk_addr = '0;
    word_t pk_data = '0;

    always @(posedge clk) begin
        bus.b_data_out <= outer_mem[bus.b_adbus];
        bus.a_data_out <= inner_mem[bus.a_adbus];
        if (bus.b_w) outer_mem[bus.b_adbus] <= bus.b_data_in;
        if (bus.a_w) inner_mem[bus.a_adbus] <= bus.a_data_in;
        if (pk_en) begin
            if (pk_sel) outer_mem[pk_addr] <= pk_data;
            else        inner_mem[pk_addr] <= pk_data;
        end
    end

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    wr_t got;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.a_w || bus.b_w) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got a_w=%0b b_w=%0b at t=%0t, expected none",
                             bus.a_w, bus.b_w, $time);
                end else begin
                    got = exp_q.pop_front();
                    if (bus.a_w && bus.b_w) begin
                        errors++;
                        $display("FAIL dual_write: got both write enables, expected one");
                    end else if (got.port !== bus.b_w ||
                                 got.addr !== (bus.b_w ? bus.b_adbus : bus.a_adbus) ||
                                 got.data !== (bus.b_w ? bus.b_data_in : bus.a_data_in)) begin
                        errors++;
                        $display("FAIL write: got port=%0b addr=%0h data=%0h expected port=%0b addr=%0h data=%0h",
                                 bus.b_w, bus.b_w ? bus.b_adbus : bus.a_adbus,
                                 bus.b_w ? bus.b_data_in : bus.a_data_in,
                                 got.port, got.addr, got.data);
                    end
                end
            end
            if ((!bus.a_w && bus.a_data_in !== '0) || (!bus.b_w && bus.b_data_in !== '0)) begin
                checks++;
                errors++;
                $display("FAIL data_idle: got a_data_in=%0h b_data_in=%0h expected 0",
                         bus.a_data_in, bus.b_data_in);
            end
        end
    end

    function automatic int exp_int(input int n);
        return (n == 0) ? 1 : (PIPE ? n + 2 : 2 * n + 1);
    endfunction
    function automatic int exp_run(input int n);
        return (n == 0) ? 0 : (PIPE ? n + 1 : 2 * n);
    endfunction

    task automatic poke(input logic sel, input addr_t a, input word_t d);
        pk_en = 1'b1; pk_sel = sel; pk_addr = a; pk_data = d;
        @(posedge clk); #1;
        pk_en = 1'b0;
    endtask

    function automatic word_t rnd_word();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, {bus.a_w, bus.b_w, bus.transfer_running, bus.interupt_transfer}, 0);
        chk({nm, "_adbus"}, {bus.a_adbus, bus.b_adbus}, 0);
        chk({nm, "_a_data"}, bus.a_data_in, 0);
        chk({nm, "_b_data"}, bus.b_data_in, 0);
    endtask

    // Preload the source, queue the expected writes, return the data used.
    task automatic setup_move(input vec_t v, input bit dead, output word_t d[3]);
        for (int k = 0; k < 3; k++) d[k] = '0;
        for (int k = 0; k < int'(v.n); k++) begin
            d[k] = dead ? {16{16'hDEAD}} : rnd_word();
            poke(v.rw, v.ra + addr_t'(k), d[k]);
            exp_q.push_back('{port: ~v.rw, addr: v.wa + addr_t'(k), data: d[k]});
        end
    endtask

    task automatic start(input vec_t v);
        bus.read_write_command = v.rw;
        bus.read_address       = v.ra;
        bus.write_address      = v.wa;
        bus.no_of_chunks       = v.n;
        bus.command_transfer   = 1'b1;
    endtask

    // Cycle 0 is the cycle the command is presented; observation covers cycles 1..ncyc.
    task automatic observe(input int ncyc, input int pulse_a, input int pulse_b, input int rst_at,
                           output int int_cyc, output int int_cnt, output int run_cnt,
                           output int first_run);
        int_cyc = -1; int_cnt = 0; run_cnt = 0; first_run = -1;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge clk); #1;
            bus.command_transfer   = (cyc == pulse_a) || (cyc == pulse_b);
            bus.read_write_command = 1'($urandom);
            bus.read_address       = addr_t'($urandom);
            bus.write_address      = addr_t'($urandom);
            bus.no_of_chunks       = 2'($urandom);
            if (cyc == rst_at) begin
                #2 rst_n = 1'b0;
                #1 chk_zero("async_reset");
                exp_q.delete();
            end
            if (rst_at > 0 && cyc == rst_at + 2) rst_n = 1'b1;
            if (bus.transfer_running) begin
                run_cnt++;
                if (first_run < 0) first_run = cyc;
            end
            if (bus.interupt_transfer) begin
                int_cnt++;
                int_cyc = cyc;
            end
        end
        bus.command_transfer = 1'b0;
    endtask

    vec_t  vecs[5];
    vec_t  v;
    word_t d[3];
    word_t keep;
    int    ic, icnt, rc, fr;

    initial begin
        bus.command_transfer = 1'b0; bus.read_write_command = 1'b0;
        bus.read_address = '0; bus.write_address = '0; bus.no_of_chunks = '0;
        for (int k = 0; k < 64; k++) begin
            outer_mem[k] = '0;
            inner_mem[k] = '0;
        end

        repeat (3) @(posedge clk);
        #1 chk_zero("in_reset");
        rst_n = 1'b1;
        @(posedge clk); #1 chk_zero("after_reset");

        vecs[0] = '{rw: 1'b1, ra: 6'h14, wa: 6'h02, n: 2'd3, exp_int: exp_int(3), exp_run: exp_run(3)};
        vecs[1] = '{rw: 1'b0, ra: 6'h05, wa: 6'h20, n: 2'd1, exp_int: exp_int(1), exp_run: exp_run(1)};
        vecs[2] = '{rw: 1'b1, ra: 6'h3f, wa: 6'h3e, n: 2'd3, exp_int: exp_int(3), exp_run: exp_run(3)};
        vecs[3] = '{rw: 1'b0, ra: 6'h11, wa: 6'h2a, n: 2'd0, exp_int: exp_int(0), exp_run: exp_run(0)};
        vecs[4] = '{rw: 1'b0, ra: 6'h3e, wa: 6'h3f, n: 2'd2, exp_int: exp_int(2), exp_run: exp_run(2)};

        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            setup_move(v, i == 1, d);
            start(v);
            observe(14, 0, 0, 0, ic, icnt, rc, fr);
            chk($sformatf("v%0d_int_cycle", i), ic, v.exp_int);
            chk($sformatf("v%0d_int_count", i), icnt, 1);
            chk($sformatf("v%0d_run_cycles", i), rc, v.exp_run);
            chk($sformatf("v%0d_run_first", i), fr, (v.n == 0) ? -1 : 1);
            chk($sformatf("v%0d_queue_empty", i), exp_q.size(), 0);
            for (int k = 0; k < int'(v.n); k++)
                chk($sformatf("v%0d_mem%0d", i, k),
                    v.rw ? inner_mem[v.wa + addr_t'(k)] : outer_mem[v.wa + addr_t'(k)], d[k]);
        end

        // Commands at cycle 2 (mid-move) and in DONE must both be ignored.
        v = '{rw: 1'b1, ra: 6'h30, wa: 6'h10, n: 2'd2, exp_int: exp_int(2), exp_run: exp_run(2)};
        setup_move(v, 1'b0, d);
        start(v);
        observe(14, 2, v.exp_int, 0, ic, icnt, rc, fr);
        chk("busy_cmd_int_cycle", ic, v.exp_int);
        chk("busy_cmd_int_count", icnt, 1);
        chk("busy_cmd_run_cycles", rc, v.exp_run);
        chk("busy_cmd_queue_empty", exp_q.size(), 0);
        chk("busy_cmd_mem0", inner_mem[6'h10], d[0]);
        chk("busy_cmd_mem1", inner_mem[6'h11], d[1]);

        // Reset at cycle 3: word 0 landed, word 1 must not, no interrupt.
        keep = rnd_word();
        poke(1'b0, 6'h19, keep);
        v = '{rw: 1'b1, ra: 6'h08, wa: 6'h18, n: 2'd3, exp_int: 0, exp_run: 0};
        setup_move(v, 1'b0, d);
        start(v);
        observe(10, 0, 0, 3, ic, icnt, rc, fr);
        chk("rst_mid_int_count", icnt, 0);
        chk("rst_mid_run_cycles", rc, 2);
        chk("rst_mid_word0", inner_mem[6'h18], d[0]);
        chk("rst_mid_word1_untouched", inner_mem[6'h19], keep);
        chk_zero("rst_mid_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
